// File: rtl/mii_rx_frame_gen.sv
// mii_rx_frame_gen: MII/GMII receive-frame generator (clk, reset, start + dst_mac/src_mac/eth_type/payload_len/payload_seed/crc_err in; rx_dv, rxd, busy, frame_done, frame_cnt out)
module mii_rx_frame_gen #(
  parameter int DATA_W      = 4,
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [47:0]       dst_mac,
  input  logic [47:0]       src_mac,
  input  logic [15:0]       eth_type,
  input  logic [15:0]       payload_len,
  input  logic [7:0]        payload_seed,
  input  logic              crc_err,
  output logic              rx_dv,
  output logic [DATA_W-1:0] rxd,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HDR, PAYLOAD, PAD, FCS, IFG} state_t;
  localparam logic [15:0] MIN_P    = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_P    = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic        WIDE     = 1'(DATA_W == 8);

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  state_t              state_q, state_d, nxt;
  logic [15:0]         cnt_q, cnt_d, len_q, len_d, frame_cnt_q, frame_cnt_d;
  logic                nib_q, nib_d, err_q, err_d;
  logic [111:0]        hdr_q, hdr_d;
  logic [7:0]          seed_q, seed_d, byte_d;
  logic [31:0]         crc_q, crc_d, fcs;
  logic                rx_dv_q, rx_dv_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   rxd_q, rxd_d;
  logic                need_pad, last_beat, last_byte;
  logic [3:0]          hdr_idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nib_d     = nib_q;
    hdr_d     = hdr_q;
    len_d     = len_q;
    seed_d    = seed_q;
    err_d     = err_q;
    need_pad  = len_q < MIN_P;
    last_beat = WIDE || nib_q;
    last_byte = 1'b0;
    nxt       = IDLE;
    case (state_q)
      PREAMBLE: begin last_byte = cnt_q == 16'd6;                 nxt = SFD; end
      SFD:      begin last_byte = 1'b1;                           nxt = HDR; end
      HDR:      begin last_byte = cnt_q == 16'd13;                nxt = len_q != 16'd0 ? PAYLOAD : need_pad ? PAD : FCS; end
      PAYLOAD:  begin last_byte = cnt_q == len_q - 16'd1;         nxt = need_pad ? PAD : FCS; end
      PAD:      begin last_byte = cnt_q + len_q == MIN_P - 16'd1; nxt = FCS; end
      FCS:      begin last_byte = cnt_q == 16'd3;                 nxt = IFG; end
      IFG:      begin last_byte = cnt_q == IFG_LAST;              nxt = IDLE; end
      default: ;
    endcase
    if (state_q == IDLE) begin
      if (start) begin
        state_d = PREAMBLE;
        cnt_d   = 16'd0;
        nib_d   = 1'b0;
        hdr_d   = {dst_mac, src_mac, eth_type};
        len_d   = payload_len > MAX_P ? MAX_P : payload_len;
        seed_d  = payload_seed;
        err_d   = crc_err;
      end
    end else begin
      nib_d = WIDE ? 1'b0 : ~nib_q;
      if (last_beat) begin
        cnt_d   = last_byte ? 16'd0 : cnt_q + 16'd1;
        state_d = last_byte ? nxt : state_q;
      end
    end
    // Outputs and CRC are computed for the beat being entered, so every output is a flop.
    hdr_idx      = 4'd13 - cnt_d[3:0];
    fcs          = ~crc_q ^ {31'b0, err_q};
    byte_d       = state_d == PREAMBLE ? 8'h55 :
                   state_d == SFD      ? 8'hD5 :
                   state_d == HDR      ? hdr_q[{hdr_idx, 3'b000} +: 8] :
                   state_d == PAYLOAD  ? seed_q + cnt_d[7:0] :
                   state_d == FCS      ? fcs[{cnt_d[1:0], 3'b000} +: 8] : 8'h00;
    rxd_d        = DATA_W'(nib_d ? byte_d >> 4 : byte_d);
    rx_dv_d      = state_d != IDLE && state_d != IFG;
    busy_d       = state_d != IDLE;
    frame_done_d = state_d == FCS && cnt_d == 16'd3 && (WIDE || nib_d);
    frame_cnt_d  = frame_cnt_q + {15'b0, frame_done_d};
    // A data byte enters the CRC on its first beat; the FCS is read only after the last one has landed.
    crc_d        = state_q == IDLE ? 32'hFFFFFFFF :
                   (state_d inside {HDR, PAYLOAD, PAD}) && !nib_d ? crc8(crc_q, byte_d) : crc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nib_q        <= 1'b0;
      hdr_q        <= '0;
      len_q        <= '0;
      seed_q       <= '0;
      err_q        <= 1'b0;
      crc_q        <= 32'hFFFFFFFF;
      rx_dv_q      <= 1'b0;
      rxd_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nib_q        <= nib_d;
      hdr_q        <= hdr_d;
      len_q        <= len_d;
      seed_q       <= seed_d;
      err_q        <= err_d;
      crc_q        <= crc_d;
      rx_dv_q      <= rx_dv_d;
      rxd_q        <= rxd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign rx_dv      = rx_dv_q;
  assign rxd        = rxd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_mii_rx_frame_gen.sv
// tb_mii_rx_frame_gen: scoreboard bench driving an MII (4-bit) and a GMII (8-bit) instance
module tb_mii_rx_frame_gen;
  logic        clk = 1'b0, reset = 1'b1, start4 = 1'b0, start8 = 1'b0;
  logic [47:0] dst, src;
  logic [15:0] typ, len;
  logic [7:0]  seed;
  logic        err;
  logic        dv4, dv8, busy4, busy8, done4, done8;
  logic [3:0]  rxd4;
  logic [7:0]  rxd8;
  logic [15:0] cnt4, cnt8;
  int          checks = 0, errors = 0;
  bit          skip4 = 1'b0;

  typedef struct {int n; int cnt; bit err;} meta_t;
  meta_t      meta4[$], meta8[$];
  logic [7:0] exp4[$], exp8[$];

  mii_rx_frame_gen #(.DATA_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .dst_mac(dst), .src_mac(src), .eth_type(typ),
    .payload_len(len), .payload_seed(seed), .crc_err(err), .rx_dv(dv4), .rxd(rxd4),
    .busy(busy4), .frame_done(done4), .frame_cnt(cnt4));
  mii_rx_frame_gen #(.DATA_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .dst_mac(dst), .src_mac(src), .eth_type(typ),
    .payload_len(len), .payload_seed(seed), .crc_err(err), .rx_dv(dv8), .rxd(rxd8),
    .busy(busy8), .frame_done(done8), .frame_cnt(cnt8));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  function automatic meta_t pop_meta(input int id);
    if (id != 0) return meta8.pop_front();
    return meta4.pop_front();
  endfunction

  function automatic logic [7:0] pop_byte(input int id);
    if (id != 0) return exp8.pop_front();
    return exp4.pop_front();
  endfunction

  task automatic set_fields(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input logic [15:0] l, input logic [7:0] sd, input logic e);
    dst = d; src = s; typ = t; len = l; seed = sd; err = e;
  endtask

  task automatic push_frame(input int id, input int cnt);
    logic [7:0]  f[$];
    logic [31:0] c;
    int          n, pad;
    meta_t       m;
    n   = len > 16'd1500 ? 1500 : int'(len);
    pad = n < 46 ? 46 - n : 0;
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src[47-8*i -: 8]);
    f.push_back(typ[15:8]);
    f.push_back(typ[7:0]);
    for (int i = 0; i < n; i++) f.push_back(seed + 8'(i));
    repeat (pad) f.push_back(8'h00);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < f.size(); i++) c = crc_upd(c, f[i]);
    c = ~c;
    c[0] = c[0] ^ err;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    foreach (f[i]) if (id != 0) exp8.push_back(f[i]); else exp4.push_back(f[i]);
    m.n = f.size(); m.cnt = cnt; m.err = err;
    if (id != 0) meta8.push_back(m); else meta4.push_back(m);
  endtask

  task automatic mon(input int id);
    logic [7:0]  rx[$];
    logic [3:0]  lo = 4'h0;
    int          beats = 0, ndone = 0, done_at = -1, idle_nz = 0;
    bit          prev = 1'b0;
    logic        dv, dn;
    logic [7:0]  d;
    logic [15:0] fc;
    logic [31:0] c;
    meta_t       m;
    forever begin
      @(negedge clk);
      dv = id != 0 ? dv8 : dv4;
      d  = id != 0 ? rxd8 : {4'h0, rxd4};
      dn = id != 0 ? done8 : done4;
      fc = id != 0 ? cnt8 : cnt4;
      if (dv === 1'b1) begin
        if (dn === 1'b1) begin ndone++; done_at = beats; end
        if (id != 0) rx.push_back(d);
        else if (beats[0]) rx.push_back({d[3:0], lo});
        else lo = d[3:0];
        beats++;
      end else begin
        if (d != 8'h00) idle_nz++;
        if (prev) begin
          if (id == 0 && skip4) skip4 = 1'b0;
          else if ((id != 0 ? meta8.size() : meta4.size()) == 0) chk("unexpected_frame", 1, 0);
          else begin
            m = pop_meta(id);
            chk("dv_cycles", beats, id != 0 ? m.n : 2 * m.n);
            chk("done_pulses", ndone, 1);
            chk("done_last_beat", done_at, beats - 1);
            chk("frame_cnt", {16'h0, fc}, m.cnt);
            for (int i = 0; i < m.n; i++)
              chk($sformatf("byte%0d", i), i < rx.size() ? {24'h0, rx[i]} : 32'h100, {24'h0, pop_byte(id)});
            c = 32'hFFFFFFFF;
            for (int i = 8; i < rx.size(); i++) c = crc_upd(c, rx[i]);
            c = ~c;
            if (m.err) chk("residue_corrupt", {31'h0, c == 32'h2144DF1C}, 0);
            else chk("residue", c, 32'h2144DF1C);
            chk("rxd_idle_zero", idle_nz, 0);
          end
          rx.delete(); beats = 0; ndone = 0; done_at = -1; idle_nz = 0;
        end
      end
      prev = dv === 1'b1;
    end
  endtask

  task automatic do_start(input int id);
    if (id != 0) start8 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_idle(input int id, input int budget);
    int k = 0;
    while ((id != 0 ? busy8 : busy4) && k < budget) begin @(negedge clk); k++; end
    chk("idle_in_budget", {31'h0, id != 0 ? busy8 : busy4}, 0);
    @(negedge clk);
  endtask

  initial begin
    int k, gap, ifg_busy;
    fork
      mon(0);
      mon(1);
    join_none
    set_fields(48'h12d146111011, 48'h59abcdef1122, 16'hab12, 16'd99, 8'h19, 1'b0);
    repeat (3) @(negedge clk);
    start4 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start4 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    chk("rst_dv4", {31'h0, dv4}, 0);      chk("rst_dv8", {31'h0, dv8}, 0);
    chk("rst_rxd4", {28'h0, rxd4}, 0);    chk("rst_rxd8", {24'h0, rxd8}, 0);
    chk("rst_busy4", {31'h0, busy4}, 0);  chk("rst_busy8", {31'h0, busy8}, 0);
    chk("rst_done4", {31'h0, done4}, 0);  chk("rst_done8", {31'h0, done8}, 0);
    chk("rst_cnt4", {16'h0, cnt4}, 0);    chk("rst_cnt8", {16'h0, cnt8}, 0);
    // frame aborted by reset while in the header
    skip4 = 1'b1;
    do_start(0);
    chk("dv_next_cycle", {31'h0, dv4}, 1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_dv", {31'h0, dv4}, 0);
    chk("abort_busy", {31'h0, busy4}, 0);
    chk("abort_cnt", {16'h0, cnt4}, 0);
    @(negedge clk);
    // main MII frame with a start pulsed during payload
    push_frame(0, 1);
    do_start(0);
    repeat (60) @(negedge clk);
    set_fields(48'hffeeddccbbaa, 48'h001122334455, 16'h0800, 16'd3, 8'h77, 1'b1);
    do_start(0);
    k = 0;
    while (done4 !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    chk("frame_a_done_seen", {31'h0, done4}, 1);
    // all-padding frame with corrupted FCS, start held so it launches at the first legal cycle
    set_fields(48'h0a0b0c0d0e0f, 48'h102030405060, 16'h88b5, 16'd0, 8'hA5, 1'b1);
    push_frame(0, 2);
    start4 = 1'b1;
    gap = 0; ifg_busy = 0;
    do begin
      @(negedge clk);
      if (dv4 !== 1'b1) begin gap++; ifg_busy += int'(busy4); end
    end while (dv4 !== 1'b1 && gap < 100);
    start4 = 1'b0;
    chk("ifg_gap", gap, 25);
    chk("ifg_busy", ifg_busy, 24);
    wait_idle(0, 400);
    // GMII: short frame with seed wrap, exact-minimum frame, clamped frame
    set_fields(48'h010203040506, 48'h0708090a0b0c, 16'h0806, 16'd10, 8'hF8, 1'b0);
    push_frame(1, 1);
    do_start(1);
    wait_idle(1, 200);
    set_fields(48'hdeadbeef0001, 48'hcafef00d0002, 16'h1234, 16'd46, 8'h00, 1'b1);
    push_frame(1, 2);
    do_start(1);
    wait_idle(1, 200);
    set_fields(48'h665544332211, 48'h112233445566, 16'h86dd, 16'd2000, 8'h3C, 1'b0);
    push_frame(1, 3);
    do_start(1);
    wait_idle(1, 2000);
    repeat (5) @(negedge clk);
    chk("pending4", meta4.size(), 0);
    chk("pending8", meta8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mii_rx_frame_gen.md
MII_RX_FRAME_GEN -- requirements
Module: mii_rx_frame_gen

Interface
REQ-001 Parameter DATA_W, default 4, meaning rxd width; legal values are 4 (MII) and 8 (GMII).
REQ-002 Parameter IFG_BYTES, default 12, meaning the inter-frame gap in byte times, legal range 1..255.
REQ-003 Parameter MIN_PAYLOAD, default 46, meaning the minimum payload bytes after padding.
REQ-004 Parameter MAX_PAYLOAD, default 1500, meaning the payload_len clamp value.
REQ-005 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that requests one frame.
REQ-008 dst_mac  input  48  destination address; byte [47:40] is sent first.
REQ-009 src_mac  input  48  source address; byte [47:40] is sent first.
REQ-010 eth_type  input  16  type/length field; byte [15:8] is sent first.
REQ-011 payload_len  input  16  requested payload byte count.
REQ-012 payload_seed  input  8  value of the first payload byte.
REQ-013 crc_err  input  1  when 1, the transmitted FCS is corrupted.
REQ-014 rx_dv  output  1  data valid.
REQ-015 rxd  output  DATA_W  frame data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 frame_done  output  1  one-cycle pulse on the last FCS beat.
REQ-018 frame_cnt  output  16  count of completed frames; wraps at 16'hFFFF.

Function
REQ-019 The FSM states SHALL be IDLE -> PREAMBLE -> SFD -> HDR -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE.
REQ-020 The FSM SHALL skip PAD when the effective payload length is at least MIN_PAYLOAD.
REQ-021 A start seen in IDLE SHALL latch all field inputs, and rx_dv SHALL go high on the next cycle.
REQ-022 A start seen in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-023 Field inputs SHALL be sampled only at the accepted start; changes after that have no effect on the frame in progress.
REQ-024 The effective payload length SHALL be min(payload_len, MAX_PAYLOAD).
REQ-025 payload_len = 0 SHALL be legal and SHALL produce a frame that is all padding.
REQ-026 PREAMBLE SHALL send 7 bytes of 8'h55.
REQ-027 SFD SHALL send 1 byte of 8'hD5.
REQ-028 HDR SHALL send dst_mac, then src_mac, then eth_type, which is 14 bytes.
REQ-029 Payload byte i SHALL equal (payload_seed + i) mod 256.
REQ-030 PAD bytes SHALL be 8'h00.
REQ-031 FCS SHALL be IEEE 802.3 CRC-32 over the HDR, PAYLOAD and PAD bytes.
REQ-032 The CRC SHALL use polynomial 04C11DB7, reflected, with initial value FFFFFFFF, and its final register SHALL be complemented.
REQ-033 FCS SHALL be sent least-significant byte first.
REQ-034 When crc_err is latched as 1, bit 0 of the first FCS byte SHALL be inverted.
REQ-035 For DATA_W = 4, each byte SHALL take two cycles, low nibble first.
REQ-036 For DATA_W = 8, each byte SHALL take one cycle.
REQ-037 rx_dv SHALL be 1 from the first preamble beat through the last FCS beat, and 0 at all other times.
REQ-038 rxd SHALL be 0 whenever rx_dv is 0.
REQ-039 The number of rx_dv-high cycles SHALL be (8 + 14 + max(L, MIN_PAYLOAD) + 4) * (8 / DATA_W), where L is the effective payload length.
REQ-040 IFG SHALL hold rx_dv at 0 for IFG_BYTES * (8 / DATA_W) cycles, and the FSM SHALL then return to IDLE.
REQ-041 A start is accepted at the earliest in the cycle after the FSM returns to IDLE.
REQ-042 frame_cnt SHALL increment in the same cycle that frame_done is pulsed.
REQ-043 frame_cnt SHALL increment whether or not crc_err was set for that frame.
REQ-044 The byte and nibble counters SHALL be sized to hold the largest frame (1526 bytes at default parameters).
REQ-045 The byte and nibble counters SHALL NOT overflow for any legal parameter set.

Reset
REQ-046 A reset in any state SHALL return the FSM to IDLE on the next clock edge.
REQ-047 On that reset, rx_dv, rxd, busy, frame_done and frame_cnt SHALL all become 0, and the CRC register SHALL become FFFFFFFF.
REQ-048 A frame aborted by reset SHALL NOT pulse frame_done and SHALL NOT increment frame_cnt.
REQ-049 A start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-050 Bench scenario (DATA_W=4): dst=12d146111011, src=59abcdef1122, type=ab12, len=99, seed=19, crc_err=0 -> 250 rx_dv cycles; the first 15 nibbles are 5, then D; the nibble after D is 2 (low nibble of 8'h12); frame_cnt=1.
REQ-051 Bench scenario, short frame (len=10, DATA_W=8) -> 72 rx_dv cycles; the ten payload bytes are seed..seed+9, followed by 36 bytes of 00.
REQ-052 Bench scenario, FCS check: a CRC-32 recomputed over HDR..FCS (complemented) SHALL equal the residue 2144DF1C when crc_err=0, and SHALL NOT equal it when crc_err=1.
REQ-053 Bench scenario, busy start: a start pulsed during PAYLOAD -> exactly one frame is produced, and the next start is honoured only after IFG (24 idle cycles for DATA_W=4).
REQ-054 Bench scenario, reset mid-HDR -> rx_dv=0 on the next cycle, frame_cnt is unchanged, and a following start produces a complete, correct frame.
REQ-055 Bench scenario, clamp: len=2000 -> the payload is exactly 1500 bytes and rx_dv is high for 1526 * (8 / DATA_W) cycles.
